// File: rtl/feed_pkg.sv
// Shared definitions for the sample feed sequencer: FSM state encoding and
// the legal range of the sample memory read latency.
package feed_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } feed_state_t;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 4;

endpackage

// File: rtl/feed_valid_pipe.sv
// Valid shift register that tracks reads in flight through the sample memory,
// producing the FIFO write strobe and a drain indicator.
module feed_valid_pipe
   import feed_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic issue,
   output logic fifo_we,
   output logic empty_c
);

   logic [RD_LAT-1:0] stage;

   generate
      if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
         $error("feed_valid_pipe: RD_LAT out of legal range");
      end

      // empty_c: nothing queued behind the stage currently driving fifo_we
      if (RD_LAT == 1) begin : g_one
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) stage <= '0;
            else      stage <= issue;
         end
         assign empty_c = 1'b1;
      end else begin : g_multi
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) stage <= '0;
            else      stage <= {stage[RD_LAT-2:0], issue};
         end
         assign empty_c = ~|stage[RD_LAT-2:0];
      end
   endgenerate

   assign fifo_we = stage[RD_LAT-1];

endmodule

// File: rtl/sample_feed_ctrl.sv
// Streams a stored sample buffer into the interpolator input FIFO under
// start/len/abort control. Optional FEED_LOOP_EN adds continuous looping.
module sample_feed_ctrl
   import feed_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned MEM_DEPTH  = 100,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH:0]   len,
`ifdef FEED_LOOP_EN
   input  logic                  loop,
`endif
   input  logic                  afull,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_re,
   output logic                  fifo_we,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  sent_cnt
);

   localparam int unsigned LEN_W = ADDR_WIDTH + 1;
   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(MEM_DEPTH);

   feed_state_t           state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [LEN_W-1:0]      len_q, len_nxt, len_clamped;
   logic                  clr_cnt;
   logic                  last_rd;
   logic                  pipe_empty;
   logic                  loop_q;

   assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
   assign last_rd     = (LEN_W'(mem_addr) == (len_q - LEN_W'(1)));

`ifdef FEED_LOOP_EN
   // Loop mode is captured with start and held for the whole transfer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                        loop_q <= 1'b0;
      else if (state == IDLE && start) loop_q <= loop;
   end
`else
   assign loop_q = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         mem_addr <= '0;
         len_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         mem_addr <= addr_nxt;
         len_q    <= len_nxt;
         busy     <= (state_nxt == RUN) || (state_nxt == FLUSH);
         done     <= (state_nxt == DONE);
      end
   end

   // Next-state, address and read-enable logic
   always_comb begin
      state_nxt = state;
      addr_nxt  = mem_addr;
      len_nxt   = len_q;
      mem_re    = 1'b0;
      clr_cnt   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               len_nxt  = len_clamped;
               addr_nxt = '0;
               clr_cnt  = 1'b1;
               // An empty transfer still passes through FLUSH for uniform done timing
               state_nxt = (len_clamped == '0) ? FLUSH : RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt = FLUSH;
            end else if (!afull) begin
               mem_re = 1'b1;
               if (last_rd) begin
                  addr_nxt = '0;
                  if (!loop_q) state_nxt = FLUSH;
               end else begin
                  addr_nxt = mem_addr + ADDR_WIDTH'(1);
               end
            end
         end
         FLUSH: begin
            if (pipe_empty) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   feed_valid_pipe #(
      .RD_LAT (RD_LAT)
   ) u_valid_pipe (
      .clk     (clk),
      .rst     (rst),
      .issue   (mem_re),
      .fifo_we (fifo_we),
      .empty_c (pipe_empty)
   );

   // Samples written since the last accepted start
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         sent_cnt <= '0;
      else if (clr_cnt) sent_cnt <= '0;
      else if (fifo_we) sent_cnt <= sent_cnt + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_sample_feed_ctrl.sv
// Directed bench for sample_feed_ctrl; three instances cover read latencies 1, 2 and 3.
module tb_sample_feed_ctrl;

   localparam int unsigned AW = 7;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start1, start2, start3, abort, afull;
   logic [AW:0]   len;
`ifdef FEED_LOOP_EN
   logic          loop;
`endif

   logic [AW-1:0] addr1, addr2, addr3;
   logic          re1, re2, re3, we1, we2, we3;
   logic          busy1, busy2, busy3, done1, done2, done3;
   logic [CW-1:0] cnt1, cnt2, cnt3;

   always #5 clk = ~clk;

   sample_feed_ctrl #(.ADDR_WIDTH(AW), .MEM_DEPTH(100), .RD_LAT(1), .CNT_WIDTH(CW)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort), .len(len),
`ifdef FEED_LOOP_EN
      .loop(loop),
`endif
      .afull(afull), .mem_addr(addr1), .mem_re(re1), .fifo_we(we1),
      .busy(busy1), .done(done1), .sent_cnt(cnt1));

   sample_feed_ctrl #(.ADDR_WIDTH(AW), .MEM_DEPTH(100), .RD_LAT(2), .CNT_WIDTH(CW)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort), .len(len),
`ifdef FEED_LOOP_EN
      .loop(loop),
`endif
      .afull(afull), .mem_addr(addr2), .mem_re(re2), .fifo_we(we2),
      .busy(busy2), .done(done2), .sent_cnt(cnt2));

   sample_feed_ctrl #(.ADDR_WIDTH(AW), .MEM_DEPTH(100), .RD_LAT(3), .CNT_WIDTH(CW)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .abort(abort), .len(len),
`ifdef FEED_LOOP_EN
      .loop(loop),
`endif
      .afull(afull), .mem_addr(addr3), .mem_re(re3), .fifo_we(we3),
      .busy(busy3), .done(done3), .sent_cnt(cnt3));

   // Output view of the instance under test
   int            sel;
   logic [AW-1:0] o_addr;
   logic          o_re, o_we, o_busy, o_done;
   logic [CW-1:0] o_cnt;

   always_comb begin
      case (sel)
         2: begin o_addr = addr2; o_re = re2; o_we = we2; o_busy = busy2; o_done = done2; o_cnt = cnt2; end
         3: begin o_addr = addr3; o_re = re3; o_we = we3; o_busy = busy3; o_done = done3; o_cnt = cnt3; end
         default: begin o_addr = addr1; o_re = re1; o_we = we1; o_busy = busy1; o_done = done1; o_cnt = cnt1; end
      endcase
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Per-transfer observations, cycle numbers relative to the start cycle
   int            nre, nwe, last_re, last_we, done_k;
   logic          first_busy, done_busy;
   logic [CW-1:0] end_cnt;
   logic [63:0]   re_bits;
   logic [AW-1:0] addrs[$];

   task automatic run_xfer(input int d, input int l, input logic lp, input int ab_after,
                           input int af_from, input int af_to, input int budget);
      logic aborted;
      sel = d; nre = 0; nwe = 0; last_re = -1; last_we = -1; done_k = -1;
      first_busy = 1'b0; done_busy = 1'b1; end_cnt = '0; re_bits = '0; aborted = 1'b0;
      addrs.delete();
      @(posedge clk); #1;
      len = (AW+1)'(l);
`ifdef FEED_LOOP_EN
      loop = lp;
`else
      if (lp) $display("note: loop request ignored in single-pass build");
`endif
      case (d)
         2: start2 = 1'b1;
         3: start3 = 1'b1;
         default: start1 = 1'b1;
      endcase
      for (int k = 1; k <= budget; k++) begin
         @(posedge clk); #1;
         start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
         afull = (k >= af_from && k <= af_to);
         abort = 1'b0;
         if (ab_after >= 0 && !aborted && nre == ab_after) begin
            abort = 1'b1;
            aborted = 1'b1;
         end
         @(negedge clk);
         if (k == 1) first_busy = o_busy;
         if (o_re) begin
            addrs.push_back(o_addr);
            nre++;
            last_re = k;
            if (k < 64) re_bits[k] = 1'b1;
         end
         if (o_we) begin
            nwe++;
            last_we = k;
         end
         if (o_done) begin
            done_k = k;
            done_busy = o_busy;
            end_cnt = o_cnt;
            break;
         end
      end
      afull = 1'b0;
      abort = 1'b0;
      check_eq("done_seen", 32'(done_k >= 0), 32'd1);
   endtask

   initial begin
      rst = 1'b0; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
      abort = 1'b0; afull = 1'b0; len = '0; sel = 1;
`ifdef FEED_LOOP_EN
      loop = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check_eq("rst_addr", 32'(addr1), 0);
      check_eq("rst_re",   32'(re1), 0);
      check_eq("rst_we",   32'(we1), 0);
      check_eq("rst_busy", 32'(busy1), 0);
      check_eq("rst_done", 32'(done1), 0);
      check_eq("rst_cnt",  32'(cnt1), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // len=5, RD_LAT=1, no throttling
      run_xfer(1, 5, 1'b0, -1, 0, -1, 30);
      check_eq("t1_nre", nre, 5);
      for (int i = 0; i < addrs.size(); i++) check_eq("t1_addr", 32'(addrs[i]), i);
      check_eq("t1_last_re", last_re, 5);
      check_eq("t1_nwe", nwe, 5);
      check_eq("t1_last_we", last_we, 6);
      check_eq("t1_done_k", done_k, 7);
      check_eq("t1_cnt", 32'(end_cnt), 5);
      check_eq("t1_busy_run", 32'(first_busy), 1);
      check_eq("t1_busy_done", 32'(done_busy), 0);

      // len=10 with afull held during cycles 3..5
      run_xfer(1, 10, 1'b0, -1, 3, 5, 40);
      check_eq("t2_re_mask", re_bits[31:0], 32'h0000_3FC6);
      check_eq("t2_nre", nre, 10);
      for (int i = 0; i < addrs.size(); i++) check_eq("t2_addr", 32'(addrs[i]), i);
      check_eq("t2_done_k", done_k, 15);
      check_eq("t2_cnt", 32'(end_cnt), 10);

      // Full buffer at RD_LAT=3
      run_xfer(3, 100, 1'b0, -1, 0, -1, 150);
      check_eq("t3_nre", nre, 100);
      for (int i = 0; i < addrs.size(); i++) check_eq("t3_addr", 32'(addrs[i]), i);
      check_eq("t3_last_re", last_re, 100);
      check_eq("t3_last_we", last_we, 103);
      check_eq("t3_done_k", done_k, 104);
      check_eq("t3_cnt", 32'(end_cnt), 100);

      // Abort after four reads at RD_LAT=2
      run_xfer(2, 20, 1'b0, 4, 0, -1, 40);
      check_eq("t4_nre", nre, 4);
      check_eq("t4_nwe", nwe, 4);
      check_eq("t4_last_we", last_we, 6);
      check_eq("t4_done_k", done_k, 7);
      check_eq("t4_cnt", 32'(end_cnt), 4);

      // Zero length: no reads, done two cycles after start
      run_xfer(1, 0, 1'b0, -1, 0, -1, 10);
      check_eq("t5_nre", nre, 0);
      check_eq("t5_done_k", done_k, 2);
      check_eq("t5_cnt", 32'(end_cnt), 0);

      // Length above memory depth is clamped
      run_xfer(2, 255, 1'b0, -1, 0, -1, 150);
      check_eq("t6_nre", nre, 100);
      if (nre > 0) check_eq("t6_last_addr", 32'(addrs[nre-1]), 99);
      check_eq("t6_done_k", done_k, 103);
      check_eq("t6_cnt", 32'(end_cnt), 100);

`ifdef FEED_LOOP_EN
      // Looping pass of three, aborted after two passes
      run_xfer(1, 3, 1'b1, 6, 0, -1, 40);
      check_eq("t7_nre", nre, 6);
      for (int i = 0; i < addrs.size(); i++) check_eq("t7_addr", 32'(addrs[i]), i % 3);
      check_eq("t7_last_re", last_re, 6);
      check_eq("t7_done_k", done_k, 9);
      check_eq("t7_cnt", 32'(end_cnt), 6);
`endif

      // Reset in the middle of a transfer
      sel = 1;
      @(posedge clk); #1;
      len = (AW+1)'(50);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      check_eq("r_busy_pre", 32'(busy1), 1);
      rst = 1'b0;
      #1;
      check_eq("r_addr", 32'(addr1), 0);
      check_eq("r_re",   32'(re1), 0);
      check_eq("r_we",   32'(we1), 0);
      check_eq("r_busy", 32'(busy1), 0);
      check_eq("r_cnt",  32'(cnt1), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run_xfer(1, 3, 1'b0, -1, 0, -1, 20);
      check_eq("r_nre", nre, 3);
      if (nre > 0) check_eq("r_first_addr", 32'(addrs[0]), 0);
      check_eq("r_cnt_end", 32'(end_cnt), 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
